// File: rtl/quad_decoder_pkg.sv
// ============================================================================
// quad_decoder_pkg : quadrature state constants, direction codes, transition
//                    classification shared by the decoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package quad_decoder_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_UP   = 2'd1,
    TR_DN   = 2'd2,
    TR_ERR  = 2'd3
  } trans_e;

  // Successor of a state when rotating in the up direction.
  function automatic logic [1:0] up_next(input logic [1:0] st);
    case (st)
      ST_00:   up_next = ST_10;
      ST_10:   up_next = ST_11;
      ST_11:   up_next = ST_01;
      default: up_next = ST_00;
    endcase
  endfunction

  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur)
      classify = TR_NONE;
    else if ((prev ^ cur) == 2'b11)
      classify = TR_ERR;
    else if (up_next(prev) == cur)
      classify = TR_UP;
    else
      classify = TR_DN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_decoder_sync2.sv
// ============================================================================
// sync2 : two-flop synchronizer with asynchronous active-low reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync2 (
  input  logic Clock,
  input  logic Resetn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
// quad_decoder : synchronised quadrature decoder with N-bit position counter,
//                step/direction pulses and sticky illegal-transition flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         A,
  input  logic         B,
  input  logic         L,
  input  logic [N-1:0] R,
  input  logic         Clr_err,
  output logic [N-1:0] Q,
  output logic         Step,
  output logic         Dir,
  output logic         Err
);

  logic         a_s;
  logic         b_s;
  logic [1:0]   s;
  trans_e       trans;

  logic [1:0]   p_q,    p_d;
  logic         v_q,    v_d;
  logic [1:0]   warm_q, warm_d;
  logic [N-1:0] q_q,    q_d;
  logic         step_q, step_d;
  logic         dir_q,  dir_d;
  logic         err_q,  err_d;

  sync2 u_sync_a (.Clock(Clock), .Resetn(Resetn), .d_i(A), .q_o(a_s));
  sync2 u_sync_b (.Clock(Clock), .Resetn(Resetn), .d_i(B), .q_o(b_s));

  assign s = {a_s, b_s};

  always_comb begin
    p_d    = s;
    v_d    = v_q;
    warm_d = {warm_q[0], 1'b1};
    q_d    = q_q;
    step_d = 1'b0;
    dir_d  = dir_q;
    err_d  = err_q & ~Clr_err;
    trans  = TR_NONE;

    // Init completes only once the synchronizer holds a post-reset sample,
    // so the reset zeros of the sync flops are never mistaken for a state.
    if (!v_q)
      v_d = warm_q[1];
    else
      trans = classify(p_q, s);

    case (trans)
      TR_UP: begin
        step_d = 1'b1;
        dir_d  = DIR_UP;
        q_d    = q_q + N'(1);
      end
      TR_DN: begin
        step_d = 1'b1;
        dir_d  = DIR_DN;
        q_d    = q_q - N'(1);
      end
      TR_ERR:  err_d = 1'b1;
      default: ;
    endcase

    if (L)
      q_d = R;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p_q    <= ST_00;
      v_q    <= 1'b0;
      warm_q <= 2'b00;
      q_q    <= '0;
      step_q <= 1'b0;
      dir_q  <= DIR_DN;
      err_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      v_q    <= v_d;
      warm_q <= warm_d;
      q_q    <= q_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
    end
  end

  assign Q    = q_q;
  assign Step = step_q;
  assign Dir  = dir_q;
  assign Err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// tb_quad_decoder : directed + randomized bench against a phase-index model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_quad_decoder;

  localparam int N = 8;

  logic         Clock;
  logic         Resetn;
  logic         A;
  logic         B;
  logic         L;
  logic [N-1:0] R;
  logic         Clr_err;
  logic [N-1:0] Q;
  logic         Step;
  logic         Dir;
  logic         Err;

  int tests;
  int fails;
  int stepcnt;

  quad_decoder #(.N(N)) dut (
    .Clock(Clock), .Resetn(Resetn), .A(A), .B(B), .L(L), .R(R),
    .Clr_err(Clr_err), .Q(Q), .Step(Step), .Dir(Dir), .Err(Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Up rotation visits phases 0,1,2,3 = 00,10,11,01.
  logic [1:0] ph [4];

  function automatic int phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_of = 0;
      2'b10:   phase_of = 1;
      2'b11:   phase_of = 2;
      default: phase_of = 3;
    endcase
  endfunction

  // Model: the decoder sees the pin value from two edges earlier; phase
  // difference of +1 is up, -1 is down, 2 is an illegal jump.
  logic [1:0]   h1, h2, mp;
  bit           hv1, hv2, minit;
  logic [N-1:0] mq;
  logic         mstep, mdir, merr;
  int           md;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      h1 = 2'b00; h2 = 2'b00; hv1 = 0; hv2 = 0; minit = 0; mp = 2'b00;
      mq = '0; mstep = 0; mdir = 0; merr = 0;
    end else begin
      md = 0;
      if (minit) begin
        md = (phase_of(h2) - phase_of(mp) + 4) % 4;
        mp = h2;
      end else if (hv2) begin
        mp = h2;
        minit = 1;
      end
      mstep = (md == 1) || (md == 3);
      if (mstep) mdir = (md == 1);
      if (md == 2) merr = 1'b1;
      else if (Clr_err) merr = 1'b0;
      if (L) mq = R;
      else if (md == 1) mq = mq + 1;
      else if (md == 3) mq = mq - 1;
      h2 = h1; hv2 = hv1;
      h1 = {A, B}; hv1 = 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare every output against the model at the falling edge.
  task automatic cyc();
    @(negedge Clock);
    check("Q",    32'(Q),    32'(mq));
    check("Step", 32'(Step), 32'(mstep));
    check("Dir",  32'(Dir),  32'(mdir));
    check("Err",  32'(Err),  32'(merr));
    if (Step === 1'b1) stepcnt++;
    #1;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {A, B} = ab;
    repeat (n) cyc();
  endtask

  int s0;
  int pos;
  int r;
  int hl;

  initial begin
    ph[0] = 2'b00; ph[1] = 2'b10; ph[2] = 2'b11; ph[3] = 2'b01;
    tests = 0; fails = 0; stepcnt = 0;
    Resetn = 1'b0; A = 1'b1; B = 1'b1; L = 1'b0; R = '0; Clr_err = 1'b0;

    repeat (2) cyc();
    check("rst_Q", 32'(Q), 32'h0);
    check("rst_Step", 32'(Step), 32'h0);
    check("rst_Dir", 32'(Dir), 32'h0);
    check("rst_Err", 32'(Err), 32'h0);

    // Inputs parked at 11 across release: init must absorb them silently.
    s0 = stepcnt;
    Resetn = 1'b1;
    repeat (10) cyc();
    check("init11_Q", 32'(Q), 32'h0);
    check("init11_Err", 32'(Err), 32'h0);
    check("init11_steps", 32'(stepcnt - s0), 32'h0);

    // Full up rotation from 00 with the latency of the first edge pinned.
    Resetn = 1'b0; {A, B} = 2'b00;
    cyc();
    Resetn = 1'b1;
    repeat (5) cyc();
    s0 = stepcnt;
    {A, B} = 2'b10;
    cyc(); check("lat_k", 32'(Step), 32'h0);
    cyc(); check("lat_k1", 32'(Step), 32'h0);
    cyc(); check("lat_k2_step", 32'(Step), 32'h1);
    check("lat_k2_Q", 32'(Q), 32'h1);
    cyc();
    hold(2'b11, 4);
    hold(2'b01, 4);
    hold(2'b00, 4);
    check("rot_Q", 32'(Q), 32'h4);
    check("rot_Dir", 32'(Dir), 32'h1);
    check("rot_steps", 32'(stepcnt - s0), 32'h4);

    // Wrap below zero, then load all-ones and wrap above.
    L = 1'b1; R = 8'h00; cyc(); L = 1'b0;
    hold(2'b01, 4);
    check("wrap_dn_Q", 32'(Q), 32'hFF);
    check("wrap_dn_Dir", 32'(Dir), 32'h0);
    L = 1'b1; R = 8'hFF; cyc(); L = 1'b0;
    hold(2'b00, 4);
    check("wrap_up_Q", 32'(Q), 32'h00);
    check("wrap_up_Dir", 32'(Dir), 32'h1);

    // Illegal jump, clear, then clear colliding with a fresh error.
    s0 = stepcnt;
    hold(2'b11, 4);
    check("err_set", 32'(Err), 32'h1);
    check("err_Q", 32'(Q), 32'h0);
    check("err_nostep", 32'(stepcnt - s0), 32'h0);
    Clr_err = 1'b1; cyc(); Clr_err = 1'b0;
    check("err_clr", 32'(Err), 32'h0);
    {A, B} = 2'b00;
    cyc(); cyc();
    Clr_err = 1'b1; cyc(); Clr_err = 1'b0;
    check("err_set_wins", 32'(Err), 32'h1);
    cyc();
    Clr_err = 1'b1; cyc(); Clr_err = 1'b0;

    // Load landing on the same edge as an up step.
    {A, B} = 2'b10;
    cyc(); cyc();
    L = 1'b1; R = 8'h5A; cyc(); L = 1'b0;
    check("ld_step_Q", 32'(Q), 32'h5A);
    check("ld_step_Step", 32'(Step), 32'h1);
    check("ld_step_Dir", 32'(Dir), 32'h1);
    repeat (3) cyc();

    // Short reset pulse while parked at 10.
    Resetn = 1'b0;
    #1;
    check("mrst_Q", 32'(Q), 32'h0);
    check("mrst_Step", 32'(Step), 32'h0);
    check("mrst_Dir", 32'(Dir), 32'h0);
    check("mrst_Err", 32'(Err), 32'h0);
    cyc();
    Resetn = 1'b1;
    s0 = stepcnt;
    repeat (6) cyc();
    check("mrst_nostep", 32'(stepcnt - s0), 32'h0);
    check("mrst_noerr", 32'(Err), 32'h0);
    hold(2'b11, 4);
    check("mrst_next_Q", 32'(Q), 32'h1);
    check("mrst_next_Dir", 32'(Dir), 32'h1);

    // Randomized walk: legal steps, illegal jumps, loads, clears, resets.
    pos = 2;
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      pos = (pos + 1) % 4;
      else if (r < 80) pos = (pos + 3) % 4;
      else if (r < 88) pos = (pos + 2) % 4;
      {A, B} = ph[pos];
      hl = $urandom_range(3, 6);
      for (int c = 0; c < hl; c++) begin
        L       = ($urandom_range(0, 19) == 0);
        R       = 8'($urandom);
        Clr_err = ($urandom_range(0, 15) == 0);
        Resetn  = ($urandom_range(0, 199) != 0);
        cyc();
      end
    end
    Resetn = 1'b1; L = 1'b0; Clr_err = 1'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
